plot_port_arbiter: RTL and testbench

//  Owns the single pixel-write port (x/y/colour/plot) of the 160x120 VGA adapter.

---
 rtl/plot_port_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_plot_port_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/plot_port_arbiter.sv
// plot_port_arbiter: owns the single pixel-write port of the 160x120 VGA adapter.
// Three box requesters are served round-robin and a full-screen clear has
// absolute priority. Boxes are rasterised one pixel per clock; the winner
// receives a one-cycle done pulse once its last pixel has been issued.
//
// Handshake: req[i] is a level request held until done[i] pulses; the box
// parameters are sampled only in the IDLE cycle that grants it. clear_req is
// a level request, sampled only in IDLE, answered by a clear_done pulse.
module plot_port_arbiter #(
  parameter int          NUM_REQ      = 3,
  parameter int          X_MAX        = 160,
  parameter int          Y_MAX        = 120,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear_req,
  output logic               clear_done,
  input  logic [NUM_REQ-1:0] req,
  input  logic [23:0]        req_x,
  input  logic [20:0]        req_y,
  input  logic [8:0]         req_col,
  input  logic [8:0]         req_w,
  input  logic [8:0]         req_h,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               busy,
  output logic [7:0]         x_out,
  output logic [6:0]         y_out,
  output logic [2:0]         colour,
  output logic               plot
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DRAW       = 3'd1,
    S_DONE       = 3'd2,
    S_CLEAR      = 3'd3,
    S_CLEAR_DONE = 3'd4
  } state_t;

  localparam logic [8:0] X_LIM  = 9'(X_MAX);
  localparam logic [7:0] Y_LIM  = 8'(Y_MAX);
  localparam logic [7:0] X_LAST = 8'(X_MAX - 1);
  localparam logic [6:0] Y_LAST = 7'(Y_MAX - 1);

  state_t state_q, state_d;
  logic [1:0]         ptr_q, ptr_d, win_q, win_d;
  logic [7:0]         bx_q, bx_d, cx_q, cx_d, x_q, x_d;
  logic [6:0]         by_q, by_d, cy_q, cy_d, y_q, y_d;
  logic [2:0]         bcol_q, bcol_d, bw_q, bw_d, bh_q, bh_d, col_q, col_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d;
  logic               clear_done_q, clear_done_d, busy_q, busy_d, plot_q, plot_d;

  // Per-requester views of the packed parameter buses (slot 3 is never selected).
  logic [7:0] rx [4];
  logic [6:0] ry [4];
  logic [2:0] rc [4];
  logic [2:0] rw [4];
  logic [2:0] rh [4];
  for (genvar g = 0; g < 3; g++) begin : g_slot
    assign rx[g] = req_x[8*g +: 8];
    assign ry[g] = req_y[7*g +: 7];
    assign rc[g] = req_col[3*g +: 3];
    assign rw[g] = req_w[3*g +: 3];
    assign rh[g] = req_h[3*g +: 3];
  end
  assign rx[3] = '0;
  assign ry[3] = '0;
  assign rc[3] = '0;
  assign rw[3] = '0;
  assign rh[3] = '0;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] v);
    return NUM_REQ'(1) << v;
  endfunction

  logic [3:0] req_ext;
  logic [1:0] rr_c1, rr_c2, rr_win;
  logic       any_req, last_box, last_clr;
  logic [8:0] x_sum;
  logic [7:0] y_sum;

  // Round-robin pick: first requester at or above ptr, wrapping mod 3.
  always_comb begin
    req_ext = 4'(req);
    any_req = |req;
    rr_c1   = inc3(ptr_q);
    rr_c2   = inc3(rr_c1);
    if (req_ext[ptr_q])      rr_win = ptr_q;
    else if (req_ext[rr_c1]) rr_win = rr_c1;
    else                     rr_win = rr_c2;
  end

  // Scan bookkeeping shared by the box and clear rasterisers.
  always_comb begin
    last_box = (cx_q == {5'd0, bw_q}) && (cy_q == {4'd0, bh_q});
    last_clr = (cx_q == X_LAST) && (cy_q == Y_LAST);
    x_sum    = {1'b0, bx_q} + {1'b0, cx_q};
    y_sum    = {1'b0, by_q} + {1'b0, cy_q};
  end

  // State and datapath registers; reset abandons any box or clear in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      bcol_q       <= '0;
      bw_q         <= '0;
      bh_q         <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      col_q        <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      clear_done_q <= 1'b0;
      busy_q       <= 1'b0;
      plot_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      bcol_q       <= bcol_d;
      bw_q         <= bw_d;
      bh_q         <= bh_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      x_q          <= x_d;
      y_q          <= y_d;
      col_q        <= col_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      clear_done_q <= clear_done_d;
      busy_q       <= busy_d;
      plot_q       <= plot_d;
    end
  end

  // Next-state: clear beats boxes in IDLE; each scan ends on its last pixel.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (clear_req)    state_d = S_CLEAR;
        else if (any_req) state_d = S_DRAW;
      end
      S_DRAW:       if (last_box) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      S_CLEAR:      if (last_clr) state_d = S_CLEAR_DONE;
      S_CLEAR_DONE: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; pixel fields hold outside DRAW/CLEAR.
  always_comb begin
    ptr_d        = ptr_q;
    win_d        = win_q;
    bx_d         = bx_q;
    by_d         = by_q;
    bcol_d       = bcol_q;
    bw_d         = bw_q;
    bh_d         = bh_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    x_d          = x_q;
    y_d          = y_q;
    col_d        = col_q;
    grant_d      = grant_q;
    done_d       = '0;
    clear_done_d = 1'b0;
    plot_d       = 1'b0;
    busy_d       = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        cx_d = '0;
        cy_d = '0;
        if (!clear_req && any_req) begin
          win_d   = rr_win;
          bx_d    = rx[rr_win];
          by_d    = ry[rr_win];
          bcol_d  = rc[rr_win];
          bw_d    = rw[rr_win];
          bh_d    = rh[rr_win];
          grant_d = onehot(rr_win);
        end
      end
      S_DRAW: begin
        x_d    = x_sum[7:0];
        y_d    = y_sum[6:0];
        col_d  = bcol_q;
        plot_d = (x_sum < X_LIM) && (y_sum < Y_LIM);
        if (cx_q == {5'd0, bw_q}) begin
          cx_d = '0;
          cy_d = cy_q + 7'd1;
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      S_DONE: begin
        grant_d = '0;
        done_d  = onehot(win_q);
        ptr_d   = inc3(win_q);
      end
      S_CLEAR: begin
        x_d    = cx_q;
        y_d    = cy_q;
        col_d  = CLEAR_COLOUR;
        plot_d = 1'b1;
        if (cx_q == X_LAST) begin
          cx_d = '0;
          cy_d = cy_q + 7'd1;
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      S_CLEAR_DONE: clear_done_d = 1'b1;
      default: ;
    endcase
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign clear_done = clear_done_q;
  assign busy       = busy_q;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour     = col_q;
  assign plot       = plot_q;

endmodule

// File: tb/tb_plot_port_arbiter.sv
// Bench for plot_port_arbiter: table of single-box vectors with a pixel
// scoreboard, plus hand-written round-robin, clear and reset sequences.
module tb_plot_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        clear_req;
  logic        clear_done;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_col, req_w, req_h;
  logic [2:0]  grant, done;
  logic        busy;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour;
  logic        plot;

  plot_port_arbiter dut (
    .clk(clk), .resetn(resetn), .clear_req(clear_req), .clear_done(clear_done),
    .req(req), .req_x(req_x), .req_y(req_y), .req_col(req_col),
    .req_w(req_w), .req_h(req_h), .grant(grant), .done(done), .busy(busy),
    .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic [2:0] w;
    logic [2:0] h;
    int         n_plot;
  } vec_t;

  vec_t        tbl [6];
  logic [18:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_box(input int idx, input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] c, input logic [2:0] w, input logic [2:0] h);
    req_x[idx*8 +: 8]   = x;
    req_y[idx*7 +: 7]   = y;
    req_col[idx*3 +: 3] = c;
    req_w[idx*3 +: 3]   = w;
    req_h[idx*3 +: 3]   = h;
  endtask

  // Drive one lone request through grant, raster and done.
  task automatic run_box(input vec_t v);
    int ex, ey, nplot;
    logic [18:0] e;
    exp_q.delete();
    for (int yy = 0; yy <= int'(v.h); yy++)
      for (int xx = 0; xx <= int'(v.w); xx++) begin
        ex = int'(v.x) + xx;
        ey = int'(v.y) + yy;
        exp_q.push_back({(ex < 160 && ey < 120) ? 1'b1 : 1'b0, v.c, ex[7:0], ey[6:0]});
      end
    set_box(v.idx, v.x, v.y, v.c, v.w, v.h);
    req[v.idx] = 1'b1;
    tick();
    chk("box_grant", grant, 32'(3'b001 << v.idx));
    chk("box_busy", busy, 1);
    nplot = 0;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      chk("box_pixel", {plot, colour, x_out, y_out}, e);
      chk("box_grant_held", grant, 32'(3'b001 << v.idx));
      if (plot) nplot++;
    end
    tick();
    chk("box_done", {done, grant, plot}, {3'b001 << v.idx, 3'b000, 1'b0});
    req[v.idx] = 1'b0;
    chk("box_nplot", nplot, v.n_plot);
    tick();
    chk("box_idle", {done, busy}, 0);
  endtask

  // Expect a 1-pixel box for idx to be granted next, then clear its request.
  task automatic serve(input int idx);
    tick();
    chk("rr_grant", grant, 32'(3'b001 << idx));
    tick();
    chk("rr_plot", plot, 1);
    tick();
    chk("rr_done", done, 32'(3'b001 << idx));
    req[idx] = 1'b0;
  endtask

  initial begin
    // idx, x, y, colour, w, h, plotted pixels
    tbl[0] = '{0, 8'd10,  7'd20,  3'b111, 3'd0, 3'd0, 1};
    tbl[1] = '{1, 8'd5,   7'd5,   3'b010, 3'd1, 3'd1, 4};
    tbl[2] = '{0, 8'd159, 7'd119, 3'b011, 3'd1, 3'd1, 1};
    tbl[3] = '{2, 8'd100, 7'd50,  3'b101, 3'd2, 3'd1, 6};
    tbl[4] = '{1, 8'd158, 7'd10,  3'b100, 3'd3, 3'd0, 2};
    tbl[5] = '{2, 8'd0,   7'd118, 3'b110, 3'd0, 3'd3, 2};

    resetn = 1'b0; clear_req = 1'b0; req = '0;
    req_x = '0; req_y = '0; req_col = '0; req_w = '0; req_h = '0;
    repeat (3) tick();
    chk("reset_outputs", {grant, done, clear_done, busy, x_out, y_out, colour, plot}, 0);
    resetn = 1'b1;
    tick();
    chk("idle_after_reset", {busy, grant}, 0);

    // Single-box vectors, ending with ptr back at 0.
    for (int i = 0; i < 6; i++) run_box(tbl[i]);

    // Round-robin: 101 from ptr 0 -> 0 then 2; 111 -> 0, 1, 2.
    for (int i = 0; i < 3; i++) set_box(i, 8'(30 + i), 7'd40, 3'b001, 3'd0, 3'd0);
    req = 3'b101;
    serve(0);
    serve(2);
    tick();
    chk("rr_idle", busy, 0);
    req = 3'b111;
    serve(0);
    serve(1);
    serve(2);
    tick();
    chk("rr_idle2", busy, 0);

    // Clear and box request raised together: clear first, then box 0.
    set_box(0, 8'd1, 7'd2, 3'b110, 3'd0, 3'd0);
    clear_req = 1'b1;
    req = 3'b001;
    tick();
    chk("clr_start", {busy, grant}, {1'b1, 3'b000});
    clear_req = 1'b0;
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++) begin
        tick();
        chk("clr_pixel", {plot, colour, x_out, y_out}, {1'b1, 3'b000, xx[7:0], yy[6:0]});
      end
    tick();
    chk("clr_done", {clear_done, plot, grant}, {1'b1, 1'b0, 3'b000});
    tick();
    chk("clr_then_grant", {clear_done, grant}, {1'b0, 3'b001});
    tick();
    chk("clr_box_pixel", {plot, colour, x_out, y_out}, {1'b1, 3'b110, 8'd1, 7'd2});
    tick();
    chk("clr_box_done", done, 32'(3'b001));
    req = '0;
    tick();

    // Reset in the middle of a 4x4 box: outputs drop at once, no done.
    set_box(1, 8'd20, 7'd30, 3'b001, 3'd3, 3'd3);
    req = 3'b010;
    tick();
    chk("rst_box_grant", grant, 32'(3'b010));
    repeat (3) tick();
    chk("rst_mid_plot", {plot, x_out, y_out}, {1'b1, 8'd22, 7'd30});
    resetn = 1'b0;
    #1;
    chk("rst_async_outputs", {grant, done, clear_done, busy, x_out, y_out, colour, plot}, 0);
    req = '0;
    repeat (3) begin
      tick();
      chk("rst_no_done", {done, busy}, 0);
    end
    resetn = 1'b1;
    set_box(2, 8'd7, 7'd9, 3'b011, 3'd0, 3'd0);
    req = 3'b100;
    tick();
    chk("post_rst_grant", grant, 32'(3'b100));
    tick();
    chk("post_rst_pixel", {plot, colour, x_out, y_out}, {1'b1, 3'b011, 8'd7, 7'd9});
    tick();
    chk("post_rst_done", done, 32'(3'b100));
    req = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
